// File: rtl/product_accumulator.sv
// product_accumulator: accumulates a frame of COUNT multiplier products into a saturating sum
//
// Purpose:
//   Sits downstream of the 4x4 array multiplier. Products arrive on a valid/ready
//   handshake and are summed with saturation at 2^ACC_W-1. After COUNT acceptances
//   the frame result is offered on a second valid/ready handshake. Together they
//   form the multiply-accumulate unit.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous frame abort, highest synchronous priority
//   in_valid   product valid
//   in_ready   block can accept a product (high in ACCUM)
//   product    unsigned 8-bit product
//   out_valid  frame result available
//   out_ready  consumer takes the result
//   acc_out    frame sum (running sum while accumulating)
//   overflow   sticky saturation flag, qualified by out_valid
//   frame_cnt  products accepted in the current frame
module product_accumulator #(
    parameter int ACC_W = 16,
    parameter int COUNT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic [7:0]       frame_cnt
);
    localparam logic [0:0] S_ACCUM = 1'b0;
    localparam logic [0:0] S_HOLD  = 1'b1;
    localparam logic [7:0] LAST    = 8'(COUNT - 1);

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [ACC_W:0]   sum;
    logic             accept;

    assign in_ready = state_q == S_ACCUM;
    assign accept   = in_valid && in_ready;
    // One extra bit catches the carry that signals saturation
    assign sum      = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, product};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = S_ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
            valid_d = 1'b0;
            cnt_d   = '0;
        end else if (state_q == S_ACCUM) begin
            if (accept) begin
                acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
                ovf_d = ovf_q | sum[ACC_W];
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end else if (valid_q && out_ready) begin
            // Result transferred: the next frame starts from zero
            state_d = S_ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ACCUM;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign acc_out   = acc_q;
    assign overflow  = ovf_q;
    assign frame_cnt = cnt_q;
endmodule
